// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM with memory ready handshake and timeout fault.
// Define ILLEGAL_TRAP_EN to trap unknown opcodes instead of treating them as NOPs.
module multicycle_controller #(
    parameter int ALUC_W      = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              Zero,
    input  logic              Lt,
    input  logic              Ltu,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              PCWrite,
    output logic              AdrSrc,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic [1:0]        ResultSrc,
    output logic [1:0]        ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic              RegWrite,
    output logic [2:0]        ImmSrc,
    output logic [ALUC_W-1:0] ALUControl,
    output logic              retire,
    output logic              fault,
    output logic [1:0]        fault_cause
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH,
        S_JAL, S_JALR, S_LUI, S_AUIPC, S_FAULT
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIM = CW'(MEM_TIMEOUT - 1);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_fault;
    logic [1:0]      r_cause;
    logic            w_wait;
    logic            w_tmo;
    logic            w_go;
    logic [1:0]      w_cause;
    logic [3:0]      w_aluc;
    logic [3:0]      w_alu_ex;
    logic [3:0]      w_alu_br;
    logic            w_taken;
    logic [2:0]      w_imm;

    assign w_wait = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                    (r_state == S_MEMWRITE);
    // Final wait cycle: mem_ready here still counts as a completion.
    assign w_tmo  = (MEM_TIMEOUT > 0) && w_wait && !mem_ready && (r_cnt == LIM);

    always_comb begin
        w_imm = 3'b000;
        unique case (op)
            OP_STORE:         w_imm = 3'b001;
            OP_BR:            w_imm = 3'b010;
            OP_JAL:           w_imm = 3'b011;
            OP_LUI, OP_AUIPC: w_imm = 3'b100;
            default:          w_imm = 3'b000;
        endcase
    end

    always_comb begin
        w_alu_ex = 4'd0;
        unique case (funct3)
            3'b000: w_alu_ex = (r_state == S_EXECR && funct7b5) ? 4'd1 : 4'd0;
            3'b001: w_alu_ex = 4'd7;
            3'b010: w_alu_ex = 4'd5;
            3'b011: w_alu_ex = 4'd6;
            3'b100: w_alu_ex = 4'd4;
            3'b101: w_alu_ex = funct7b5 ? 4'd9 : 4'd8;
            3'b110: w_alu_ex = 4'd3;
            default: w_alu_ex = 4'd2;
        endcase
    end

    always_comb begin
        w_alu_br = 4'd1;
        w_taken  = 1'b0;
        unique case (funct3)
            3'b000:  w_taken = Zero;
            3'b001:  w_taken = !Zero;
            3'b100:  begin w_alu_br = 4'd5; w_taken = Lt;   end
            3'b101:  begin w_alu_br = 4'd5; w_taken = !Lt;  end
            3'b110:  begin w_alu_br = 4'd6; w_taken = Ltu;  end
            3'b111:  begin w_alu_br = 4'd6; w_taken = !Ltu; end
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next    = r_state;
        w_go      = 1'b0;
        w_cause   = 2'b00;
        mem_req   = 1'b0;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        RegWrite  = 1'b0;
        ImmSrc    = 3'b000;
        w_aluc    = 4'd0;
        retire    = 1'b0;
        // Everything is forced low while reset is held.
        if (reset_n) begin
            ImmSrc = w_imm;
            unique case (r_state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        w_next  = S_DECODE;
                    end else if (w_tmo) begin
                        w_next  = S_FAULT;
                        w_go    = 1'b1;
                        w_cause = 2'b01;
                    end
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    unique case (op)
                        OP_LOAD, OP_STORE: w_next = S_MEMADR;
                        OP_R:              w_next = S_EXECR;
                        OP_I:              w_next = S_EXECI;
                        OP_BR:             w_next = S_BRANCH;
                        OP_JAL:            w_next = S_JAL;
                        OP_JALR:           w_next = S_JALR;
                        OP_LUI:            w_next = S_LUI;
                        OP_AUIPC:          w_next = S_AUIPC;
                        default: begin
`ifdef ILLEGAL_TRAP_EN
                            w_next  = S_FAULT;
                            w_go    = 1'b1;
                            w_cause = 2'b10;
`else
                            w_next  = S_FETCH;
                            retire  = 1'b1;
`endif
                        end
                    endcase
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    w_next  = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                    if (mem_ready) begin
                        w_next = S_MEMWB;
                    end else if (w_tmo) begin
                        w_next  = S_FAULT;
                        w_go    = 1'b1;
                        w_cause = 2'b01;
                    end
                end
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                    retire    = 1'b1;
                    w_next    = S_FETCH;
                end
                S_MEMWRITE: begin
                    mem_req  = 1'b1;
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                    if (mem_ready) begin
                        retire = 1'b1;
                        w_next = S_FETCH;
                    end else if (w_tmo) begin
                        w_next  = S_FAULT;
                        w_go    = 1'b1;
                        w_cause = 2'b01;
                    end
                end
                S_EXECR, S_EXECI: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = (r_state == S_EXECI) ? 2'b01 : 2'b00;
                    w_aluc  = w_alu_ex;
                    w_next  = S_ALUWB;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                    w_next   = S_FETCH;
                end
                S_BRANCH: begin
                    ALUSrcA = 2'b10;
                    w_aluc  = w_alu_br;
                    PCWrite = w_taken;
                    retire  = 1'b1;
                    w_next  = S_FETCH;
                end
                S_JAL: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    PCWrite = 1'b1;
                    w_next  = S_ALUWB;
                end
                S_JALR: begin
                    ALUSrcA   = 2'b10;
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    PCWrite   = 1'b1;
                    w_next    = S_ALUWB;
                end
                S_LUI: begin
                    ResultSrc = 2'b11;
                    RegWrite  = 1'b1;
                    retire    = 1'b1;
                    w_next    = S_FETCH;
                end
                S_AUIPC: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    w_next  = S_ALUWB;
                end
                default: w_next = S_FAULT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
            r_fault <= 1'b0;
            r_cause <= 2'b00;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (w_wait && !mem_ready)
                r_cnt <= r_cnt + 1'b1;
            if (w_go) begin
                r_fault <= 1'b1;
                r_cause <= w_cause;
            end
        end
    end

    assign ALUControl  = ALUC_W'(w_aluc);
    assign fault       = r_fault;
    assign fault_cause = r_cause;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction stream checked cycle by cycle against a
// per-instruction expansion of the control sequence.
module tb_multicycle_controller;

    localparam int TMO = 16;

    typedef struct packed {
        logic [1:0] cause;
        logic       flt;
        logic       ret;
        logic [3:0] aluc;
        logic [2:0] imm;
        logic       regw;
        logic [1:0] b;
        logic [1:0] a;
        logic [1:0] res;
        logic       irw;
        logic       memw;
        logic       adr;
        logic       pcw;
        logic       mreq;
    } cw_t;

    typedef struct {
        bit         rst;
        bit         rdy;
        logic [6:0] op;
        logic [2:0] f3;
        bit         f7, z, lt, ltu;
        cw_t        e;
        cw_t        m;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset_n, Zero, Lt, Ltu, mem_ready, funct7b5;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, fault_cause;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic       retire, fault;

    always #5 clk = ~clk;

    multicycle_controller #(.ALUC_W(4), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .Zero(Zero), .Lt(Lt), .Ltu(Ltu),
        .mem_ready(mem_ready), .mem_req(mem_req), .PCWrite(PCWrite),
        .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .retire(retire), .fault(fault), .fault_cause(fault_cause)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    ent_t       q[$];
    cw_t        E, M;
    logic [22:0] act, cur_e, cur_m;
    bit         exp_v = 0;
    logic [6:0] c_op;
    logic [2:0] c_f3;
    bit         c_f7, c_z, c_lt, c_ltu;

    assign act = {fault_cause, fault, retire, ALUControl, ImmSrc, RegWrite,
                  ALUSrcB, ALUSrcA, ResultSrc, IRWrite, MemWrite, AdrSrc,
                  PCWrite, mem_req};

    task automatic chk(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, a, e);
        end
    endtask

    function automatic logic [2:0] immof(input logic [6:0] o);
        case (o)
            7'b0100011:             return 3'b001;
            7'b1100011:             return 3'b010;
            7'b1101111:             return 3'b011;
            7'b0110111, 7'b0010111: return 3'b100;
            default:                return 3'b000;
        endcase
    endfunction

    function automatic logic [3:0] aluexp(input logic [2:0] f3, input bit f7,
                                          input bit isr);
        case (f3)
            3'b000:  return (isr && f7) ? 4'd1 : 4'd0;
            3'b001:  return 4'd7;
            3'b010:  return 4'd5;
            3'b011:  return 4'd6;
            3'b100:  return 4'd4;
            3'b101:  return f7 ? 4'd9 : 4'd8;
            3'b110:  return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    task automatic start();
        E = '0;
        M = '0;
        M.mreq = 1; M.pcw = 1; M.memw = 1; M.irw = 1; M.regw = 1;
        M.ret = 1; M.flt = 1; M.cause = '1; M.imm = '1;
        E.imm = immof(c_op);
    endtask

    task automatic put(input bit rdy, input bit rst = 0);
        ent_t x;
        x.rst = rst; x.rdy = rdy; x.op = c_op; x.f3 = c_f3; x.f7 = c_f7;
        x.z = c_z; x.lt = c_lt; x.ltu = c_ltu; x.e = E; x.m = M;
        q.push_back(x);
    endtask

    task automatic alu(input logic [1:0] a, input logic [1:0] b,
                       input logic [3:0] c);
        E.a = a; M.a = '1; E.b = b; M.b = '1; E.aluc = c; M.aluc = '1;
    endtask

    task automatic rs(input logic [1:0] v);
        E.res = v; M.res = '1;
    endtask

    task automatic rst_cycles(input int n);
        E = '0;
        M = '1;
        repeat (n) put(1'($urandom_range(0, 1)), 1);
    endtask

    task automatic do_fault(input logic [1:0] cause);
        start();
        E.flt = 1;
        E.cause = cause;
        repeat (3) put(1'($urandom_range(0, 1)));
        rst_cycles(2);
    endtask

    task automatic waits(input int w, output bit to);
        int n;
        n = (w >= TMO) ? TMO : w;
        repeat (n) put(0);
        to = (w >= TMO);
    endtask

    task automatic wb();
        start(); rs(2'b00); E.regw = 1; E.ret = 1;
        put(1'($urandom_range(0, 1)));
    endtask

    task automatic instr(input logic [6:0] o, input logic [2:0] f3,
                         input bit f7, input bit z, input bit lt,
                         input bit ltu, input int wf, input int wm);
        bit to;
        bit r;
        c_op = o; c_f3 = f3; c_f7 = f7; c_z = z; c_lt = lt; c_ltu = ltu;
        r = 1'($urandom_range(0, 1));
        start(); alu(2'b00, 2'b10, 4'd0); rs(2'b10);
        E.adr = 0; M.adr = 1; E.mreq = 1;
        waits(wf, to);
        if (to) begin do_fault(2'b01); return; end
        E.irw = 1; E.pcw = 1;
        put(1);
        start(); alu(2'b01, 2'b01, 4'd0);
        case (o)
            7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: put(r);
            default: begin
`ifdef ILLEGAL_TRAP_EN
                put(r);
                do_fault(2'b10);
`else
                E.ret = 1;
                put(r);
`endif
                return;
            end
        endcase
        start();
        case (o)
            7'b0000011, 7'b0100011: begin
                alu(2'b10, 2'b01, 4'd0);
                put(r);
                start(); E.mreq = 1; E.adr = 1; M.adr = 1;
                if (o == 7'b0100011) E.memw = 1;
                waits(wm, to);
                if (to) begin do_fault(2'b01); return; end
                if (o == 7'b0100011) begin
                    E.ret = 1;
                    put(1);
                end else begin
                    put(1);
                    start(); rs(2'b01); E.regw = 1; E.ret = 1;
                    put(r);
                end
            end
            7'b0110011, 7'b0010011: begin
                alu(2'b10, (o == 7'b0110011) ? 2'b00 : 2'b01,
                    aluexp(f3, f7, o == 7'b0110011));
                put(r);
                wb();
            end
            7'b1100011: begin
                alu(2'b10, 2'b00, (f3[2:1] == 2'b10) ? 4'd5 :
                                  (f3[2:1] == 2'b11) ? 4'd6 : 4'd1);
                if (f3[2:1] == 2'b01) M.aluc = '0;
                rs(2'b00);
                E.ret = 1;
                case (f3)
                    3'b000:  E.pcw = z;
                    3'b001:  E.pcw = !z;
                    3'b100:  E.pcw = lt;
                    3'b101:  E.pcw = !lt;
                    3'b110:  E.pcw = ltu;
                    3'b111:  E.pcw = !ltu;
                    default: E.pcw = 0;
                endcase
                put(r);
            end
            7'b1101111: begin
                alu(2'b01, 2'b10, 4'd0); rs(2'b00); E.pcw = 1;
                put(r);
                wb();
            end
            7'b1100111: begin
                alu(2'b10, 2'b01, 4'd0); rs(2'b10); E.pcw = 1;
                put(r);
                wb();
            end
            7'b0110111: begin
                rs(2'b11); E.regw = 1; E.ret = 1;
                put(r);
            end
            default: begin
                alu(2'b01, 2'b01, 4'd0);
                put(r);
                wb();
            end
        endcase
    endtask

    function automatic int pickw();
        int r;
        r = $urandom_range(0, 99);
        if (r < 60) return 0;
        if (r < 90) return $urandom_range(1, 4);
        if (r < 96) return TMO - 1;
        return TMO;
    endfunction

    function automatic logic [6:0] pickop();
        case ($urandom_range(0, 10))
            0:  return 7'b0000011;
            1:  return 7'b0100011;
            2:  return 7'b0110011;
            3:  return 7'b0010011;
            4:  return 7'b1100011;
            5:  return 7'b1101111;
            6:  return 7'b1100111;
            7:  return 7'b0110111;
            8:  return 7'b0010111;
            9:  return 7'b1111111;
            default: return 7'b0000000;
        endcase
    endfunction

    initial begin
        int n0, c;
        bit found;
        reset_n = 0; mem_ready = 0; op = '0; funct3 = '0; funct7b5 = 0;
        Zero = 0; Lt = 0; Ltu = 0;
        c_op = '0; c_f3 = '0; c_f7 = 0; c_z = 0; c_lt = 0; c_ltu = 0;

        fork
            forever begin
                @(negedge clk);
                if (exp_v) begin
                    checks++;
                    if (((act ^ cur_e) & cur_m) != '0) begin
                        errors++;
                        $display("FAIL ctl cyc=%0d got=%h expected=%h mask=%h",
                                 cyc, act, cur_e, cur_m);
                    end
                end
            end
        join_none

        rst_cycles(2);
        n0 = q.size();
        instr(7'b0110011, 3'b000, 0, 0, 0, 0, 0, 0);
        chk("add_len", q.size() - n0, 4);
        n0 = q.size();
        instr(7'b0000011, 3'b010, 0, 0, 0, 0, 0, 3);
        chk("lw_len", q.size() - n0, 8);
        n0 = q.size();
        instr(7'b1100011, 3'b101, 0, 0, 0, 0, 0, 0);
        chk("bge_len", q.size() - n0, 3);
        chk("bge_taken", int'(q[q.size() - 1].e.pcw), 1);
        instr(7'b1100011, 3'b101, 0, 0, 1, 0, 0, 0);
        chk("bge_not", int'(q[q.size() - 1].e.pcw), 0);
        instr(7'b0010011, 3'b101, 1, 0, 0, 0, 0, 0);
        chk("srai_alu", int'(q[q.size() - 2].e.aluc), 9);
        instr(7'b0010011, 3'b000, 1, 0, 0, 0, 0, 0);
        chk("addi_alu", int'(q[q.size() - 2].e.aluc), 0);
        instr(7'b1111111, 3'b000, 0, 0, 0, 0, 0, 0);
        instr(7'b0110011, 3'b111, 0, 0, 0, 0, TMO - 1, 0);
        instr(7'b0100011, 3'b010, 0, 0, 0, 0, 0, 5);
        repeat (4) void'(q.pop_back());
        rst_cycles(2);
        instr(7'b0100011, 3'b010, 0, 0, 0, 0, 0, TMO);
        instr(7'b0000011, 3'b010, 0, 0, 0, 0, 0, TMO - 1);
        repeat (250)
            instr(pickop(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), pickw(), pickw());

        foreach (q[i]) begin
            @(posedge clk);
            #1;
            cyc = i;
            reset_n = !q[i].rst;
            mem_ready = q[i].rdy;
            op = q[i].op; funct3 = q[i].f3; funct7b5 = q[i].f7;
            Zero = q[i].z; Lt = q[i].lt; Ltu = q[i].ltu;
            cur_e = q[i].e;
            cur_m = q[i].m;
            exp_v = 1;
        end
        @(posedge clk);
        #1;
        exp_v = 0;

        reset_n = 0; mem_ready = 0; op = 7'b0110011;
        @(posedge clk);
        #1;
        reset_n = 1;
        c = 0;
        found = 0;
        while (!found && c < 40) begin
            @(negedge clk);
            c++;
            found = fault;
        end
        chk("tmo_cycle", found ? c : -1, 17);
        chk("tmo_cause", int'(fault_cause), 1);
        repeat (5) @(negedge clk);
        chk("tmo_sticky", int'(fault), 1);
        chk("tmo_no_req", int'(mem_req), 0);
        @(posedge clk);
        #1;
        reset_n = 0;
        @(negedge clk);
        chk("rst_fault", int'(fault), 0);
        chk("rst_memreq", int'(mem_req), 0);
        @(posedge clk);
        #1;
        reset_n = 1;
        @(negedge clk);
        chk("fetch_req", int'(mem_req), 1);
        chk("fetch_cause", int'(fault_cause), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multicycle RV32I control unit; successor to the single-cycle controller.
- One FSM sequences fetch, decode, execute, memory and writeback over several cycles, with a ready handshake on the shared instruction/data memory.
- Supports full branch set (beq/bne/blt/bge/bltu/bgeu), jal, jalr, lui, auipc, plus a memory-timeout fault.
- Sits between the instruction register/flags of the datapath and its mux/enable controls.

Parameters:
- ALUC_W, 4, ALUControl width; codes below use the low 4 bits, upper bits zero.
- MEM_TIMEOUT, 16, max consecutive wait cycles with mem_ready low before fault; 0 disables timeout.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- op  in  7  opcode from IR
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- Zero  in  1  ALU result zero
- Lt  in  1  signed A<B
- Ltu  in  1  unsigned A<B
- mem_ready  in  1  memory access completes this cycle
- mem_req  out  1  memory access active
- PCWrite  out  1  PC load enable
- AdrSrc  out  1  0=PC, 1=Result
- MemWrite  out  1  store strobe
- IRWrite  out  1  IR/OldPC load
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1
- ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 const 4
- RegWrite  out  1  register-file write enable
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- ALUControl  out  ALUC_W  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra
- retire  out  1  one-cycle pulse on the instruction's final cycle
- fault  out  1  sticky fault
- fault_cause  out  2  01 timeout, 10 illegal opcode

Behaviour:
Reset
- reset_n low: state=FETCH, wait counter=0, fault=0, fault_cause=00.
- All strobes (PCWrite, IRWrite, MemWrite, RegWrite, mem_req, retire) are 0 during reset.
- Mux selects during reset: 0.
- Reset asserted mid-access aborts the access with no write.

States and outputs (unlisted strobes=0):
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - When mem_ready: IRWrite=1, PCWrite=1, then go to DECODE. Otherwise stay.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/jal target into ALUOut). Next state by op:
  - 0000011 / 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - else -> FETCH (NOP) with retire=1.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next is MEMREAD (load) or MEMWRITE (store).
- MEMREAD: mem_req=1, AdrSrc=1. On mem_ready go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire=1, then FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1 held until mem_ready. On mem_ready: retire=1, then FETCH.
- EXECR / EXECI:
  - ALUSrcA=10; ALUSrcB=00 for EXECR, 01 for EXECI.
  - ALU op from funct3: 000 add/sub, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra, 110 or, 111 and.
  - sub only in EXECR with funct7b5=1.
  - sra when funct3=101 and funct7b5=1 (both types).
  - Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire=1, then FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, sub for beq/bne, slt for blt/bge, sltu for bltu/bgeu. ResultSrc=00.
  - PCWrite = taken, where taken is: beq Zero, bne !Zero, blt Lt, bge !Lt, bltu Ltu, bgeu !Ltu.
  - funct3 010/011: never taken.
  - retire=1, then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 (target from ALUOut); next ALUWB (writes PC+4).
- JALR: ALUSrcA=10, ALUSrcB=01, add, ResultSrc=10, PCWrite=1; next ALUWB.
  - ALUOut latches PC+4 via datapath OldPC path.
- LUI: ResultSrc=11, RegWrite=1, retire=1, then FETCH.
- AUIPC: ALUSrcA=01, ALUSrcB=01, add; next ALUWB.
- ImmSrc: combinational from op in every state: I for load/op-imm/jalr, S store, B branch, J jal, U lui/auipc, 000 otherwise.
- FAULT: all strobes 0, fault=1; held until reset.

Timeout
- Counter increments each cycle the FSM is in FETCH, MEMREAD or MEMWRITE with mem_ready=0; it clears on state change.
- When MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT: go to FAULT, fault_cause=01, and MemWrite drops.
- mem_ready arriving on the same cycle as the limit is a completion, not a fault.

Optional Feature:
- ILLEGAL_TRAP_EN
  - Defined: an unknown opcode in DECODE goes to FAULT with fault_cause=10 and no retire.
  - Undefined: an unknown opcode is a NOP (DECODE->FETCH, retire=1), and fault_cause=10 is never produced.

Test Plan:
- add: op=0110011, funct3=000, funct7b5=0, mem_ready=1 -> FETCH, DECODE, EXECR (ALUControl=0), ALUWB (RegWrite=1, retire=1); 4 cycles.
- lw with memory 3 wait cycles -> MEMREAD holds mem_req=1, AdrSrc=1 for 4 cycles; MEMWB RegWrite=1, ResultSrc=01; total 5+3 cycles.
- bge (funct3=101), Lt=0 -> PCWrite=1 in BRANCH; Lt=1 -> PCWrite=0; both retire after 3 cycles.
- srai: op=0010011, funct3=101, funct7b5=1 -> ALUControl=9; same with funct3=000, funct7b5=1 -> ALUControl=0 (addi, not sub).
- MEM_TIMEOUT=16, mem_ready stuck low in FETCH -> fault=1, fault_cause=01 on the 17th cycle; stays until reset_n pulse, then FETCH with fault=0.
- op=1111111 -> with ILLEGAL_TRAP_EN: fault=1, cause=10; without: retire=1, back to FETCH.
